// File: rtl/port2_display_pkg.sv
// Shared types for the port 2 display front-end: segment pattern and scan FSM states.
package port2_display_pkg;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;

    typedef enum logic [0:0] {
        SCAN_BLANK = 1'b0,
        SCAN_DRIVE = 1'b1
    } scan_state_t;
endpackage

// File: rtl/port2_display_scan_if.sv
// Port 2 input pattern plus multiplexed display outputs; the display block is the slave.
interface port2_display_scan_if #(
    parameter int DIGITS = 4
);
    import port2_display_pkg::*;

    localparam int FILL_W = $clog2(DIGITS + 1);

    seg_t              port2_data;
    seg_t              seg_out;
    logic [DIGITS-1:0] digit_en;
    logic              new_value;
    logic [FILL_W-1:0] filled;

    modport master (output port2_data, input seg_out, digit_en, new_value, filled);
    modport slave  (input port2_data, output seg_out, digit_en, new_value, filled);
endinterface

// File: rtl/port2_glitch_filter.sv
// Glitch filter: a pattern must be sampled STABLE_CYCLES+1 times in a row before it commits.
// commit_pulse_o is combinational and fires on the edge the final identical sample is taken.
module port2_glitch_filter
    import port2_display_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  seg_t sample_i,
    output logic commit_pulse_o,
    output seg_t commit_value_o
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    seg_t             candidate_q, candidate_d;
    seg_t             committed_q, committed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             same;
    logic             commit;

    // cnt == 0 already represents one sample of candidate, so commit when cnt is about to reach max
    always_comb begin
        same        = (sample_i == candidate_q);
        commit      = same && (cnt_q >= CNT_LAST) && (candidate_q != committed_q);
        candidate_d = candidate_q;
        cnt_d       = cnt_q;
        committed_d = committed_q;
        if (!same) begin
            candidate_d = sample_i;
            cnt_d       = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (commit) begin
            committed_d = candidate_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            candidate_q <= SEG_BLANK;
            committed_q <= SEG_BLANK;
            cnt_q       <= '0;
        end else begin
            candidate_q <= candidate_d;
            committed_q <= committed_d;
            cnt_q       <= cnt_d;
        end
    end

    assign commit_pulse_o = commit;
    assign commit_value_o = candidate_q;
endmodule

// File: rtl/port2_display_scan.sv
// Filtered port 2 patterns pushed into a DIGITS-deep history, scanned onto a shared segment bus.
// Outputs are registered one cycle behind the scan counters so segments and enables move together.
module port2_display_scan
    import port2_display_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int SCAN_DIV      = 1000,
    parameter int BLANK_CYCLES  = 2,
    parameter int STABLE_CYCLES = 4
) (
    input logic                  clock,
    input logic                  reset,
    port2_display_scan_if.slave  bus
);
    localparam int FILL_W = $clog2(DIGITS + 1);
    localparam int IDX_W  = $clog2(DIGITS);
    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam logic [FILL_W-1:0] FILL_MAX   = FILL_W'(DIGITS);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_BLANK = SLOT_W'(BLANK_CYCLES);

    logic commit_pulse;
    seg_t commit_value;

    port2_glitch_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clock          (clock),
        .reset          (reset),
        .sample_i       (bus.port2_data),
        .commit_pulse_o (commit_pulse),
        .commit_value_o (commit_value)
    );

    seg_t              digit_q [DIGITS];
    logic [FILL_W-1:0] filled_q;
    logic              new_value_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < DIGITS; k++) digit_q[k] <= SEG_BLANK;
            filled_q    <= '0;
            new_value_q <= 1'b0;
        end else begin
            new_value_q <= commit_pulse;
            if (commit_pulse) begin
                for (int k = DIGITS - 1; k > 0; k--) digit_q[k] <= digit_q[k-1];
                digit_q[0] <= commit_value;
                if (filled_q != FILL_MAX) filled_q <= filled_q + FILL_W'(1);
            end
        end
    end

    scan_state_t       state_q, state_d;
    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    seg_t              seg_q, seg_d;
    logic [DIGITS-1:0] digit_en_q, digit_en_d;

    always_comb begin
        slot_cnt_d = slot_cnt_q + SLOT_W'(1);
        idx_d      = idx_q;
        if (slot_cnt_q == SLOT_LAST) begin
            slot_cnt_d = '0;
            idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        state_d = (slot_cnt_d >= SLOT_BLANK) ? SCAN_DRIVE : SCAN_BLANK;

        seg_d      = SEG_BLANK;
        digit_en_d = '0;
        if (state_q == SCAN_DRIVE) begin
            digit_en_d = DIGITS'(1) << idx_q;
            if (FILL_W'(idx_q) < filled_q) seg_d = digit_q[idx_q];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= SCAN_BLANK;
            slot_cnt_q <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_BLANK;
            digit_en_q <= '0;
        end else begin
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            digit_en_q <= digit_en_d;
        end
    end

    assign bus.seg_out   = seg_q;
    assign bus.digit_en  = digit_en_q;
    assign bus.new_value = new_value_q;
    assign bus.filled    = filled_q;
endmodule

// File: tb/tb_port2_display_scan.sv
// Scoreboarded bench: a window-based reference model predicts every output cycle.
module tb_port2_display_scan;
    import port2_display_pkg::*;

    localparam int DIGITS = 4;
    localparam int SCAN_DIV = 8;
    localparam int BLANK = 2;
    localparam int STABLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    port2_display_scan_if #(.DIGITS(DIGITS)) bus ();

    port2_display_scan #(
        .DIGITS        (DIGITS),
        .SCAN_DIV      (SCAN_DIV),
        .BLANK_CYCLES  (BLANK),
        .STABLE_CYCLES (STABLE)
    ) u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [6:0] seg;
        logic [3:0] den;
        logic       nv;
        logic [2:0] filled;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;

    // Reference model: recent sample window, last committed value, newest-first digit list,
    // and the number of clock edges since reset release.
    logic [6:0] hist[$];
    logic [6:0] committed;
    logic [6:0] shown[$];
    int         ecount;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        hist = {};
        hist.push_back(7'h00);
        committed = 7'h00;
        shown = {};
        ecount = 0;
    endtask

    task automatic step(input logic r, input logic [6:0] v);
        exp_t x;
        int   slot;
        int   idx;
        bit   drive;
        bit   commit;
        @(negedge clk);
        rst = r;
        bus.port2_data = v;
        x.seg = 7'h00;
        x.den = 4'h0;
        x.nv = 1'b0;
        x.filled = 3'd0;
        if (r) begin
            model_reset();
        end else begin
            slot  = ecount % SCAN_DIV;
            idx   = (ecount / SCAN_DIV) % DIGITS;
            drive = (slot >= BLANK);
            if (drive) begin
                x.den = 4'(1 << idx);
                if (idx < shown.size()) x.seg = shown[idx];
            end
            hist.push_back(v);
            if (hist.size() > STABLE + 1) void'(hist.pop_front());
            commit = (hist.size() == STABLE + 1) && (v != committed);
            foreach (hist[i]) if (hist[i] != v) commit = 1'b0;
            if (commit) begin
                shown.push_front(v);
                if (shown.size() > DIGITS) void'(shown.pop_back());
                committed = v;
            end
            x.nv = commit;
            x.filled = 3'(shown.size());
            ecount++;
        end
        exp_q.push_back(x);
    endtask

    task automatic hold(input logic [6:0] v, input int n);
        repeat (n) step(1'b0, v);
    endtask

    // Monitor: outputs are valid every cycle, compare just after each rising edge.
    initial begin
        forever begin
            exp_t x;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("seg_out",   int'(bus.seg_out),   int'(x.seg));
                chk("digit_en",  int'(bus.digit_en),  int'(x.den));
                chk("new_value", int'(bus.new_value), int'(x.nv));
                chk("filled",    int'(bus.filled),    int'(x.filled));
            end
        end
    end

    initial begin
        logic [6:0] pat [6];
        logic [6:0] v;
        pat[0] = 7'h3F; pat[1] = 7'h06; pat[2] = 7'h5B;
        pat[3] = 7'h4F; pat[4] = 7'h66; pat[5] = 7'h00;
        bus.port2_data = 7'h00;
        model_reset();

        repeat (3) step(1'b1, 7'h00);
        hold(7'h00, 4);
        hold(7'h3F, 12);
        hold(7'h06, 3);
        hold(7'h3F, 6);
        hold(7'h06, 6);
        hold(7'h5B, 6);
        hold(7'h4F, 6);
        hold(7'h66, 40);
        hold(7'h66, 20);
        hold(7'h00, 8);

        repeat (150) begin
            v = pat[$urandom_range(0, 5)];
            if ($urandom_range(0, 6) == 0) v = 7'($urandom);
            hold(v, $urandom_range(1, 7));
        end

        // Bring the scan to the middle of digit 2's drive window, then reset.
        hold(7'h5B, 6);
        for (int i = 0; i < 64; i++) begin
            if (((ecount / SCAN_DIV) % DIGITS == 2) && (ecount % SCAN_DIV == 4)) break;
            step(1'b0, 7'h5B);
        end
        chk("reached_mid_drive_idx2", (ecount / SCAN_DIV) % DIGITS * SCAN_DIV + ecount % SCAN_DIV,
            2 * SCAN_DIV + 4);
        step(1'b1, 7'h5B);
        hold(7'h5B, 2);
        hold(7'h3F, 40);

        @(posedge clk);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
